// File: rtl/rej_sample_packer.sv
// Rejection sampler and coefficient packer: slices a word stream LSB-first into
// COEF_W-bit candidates, keeps those below Q (or all in bypass), packs PACK per output word.
`timescale 1ns/1ps
module rej_sample_packer #(
    parameter int DIN_W  = 32,
    parameter int COEF_W = 12,
    parameter int Q      = 3329,
    parameter int PACK   = 2,
    parameter int NCOEF  = 256,
    parameter int BUF_W  = 64,
    parameter int CW     = $clog2(NCOEF + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   bypass,
    input  logic                   s_valid,
    input  logic [DIN_W-1:0]       s_data,
    output logic                   s_ready,
    output logic                   m_valid,
    output logic [PACK*COEF_W-1:0] m_data,
    output logic                   m_last,
    input  logic                   m_ready,
    output logic                   done,
    output logic [CW-1:0]          coef_cnt,
    output logic [15:0]            drop_cnt
);
    localparam int BCW = $clog2(BUF_W + 1);
    localparam int SW  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int OW  = PACK * COEF_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v != 16'hFFFF) begin
            sat_inc16 = v + 16'd1;
        end else begin
            sat_inc16 = v;
        end
    endfunction

    logic [1:0]       state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [BCW-1:0]   buf_cnt_q, buf_cnt_d;
    logic [OW-1:0]    slot_q, slot_d;
    logic [SW-1:0]    slot_cnt_q, slot_cnt_d;
    logic [OW-1:0]    m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             m_last_q, m_last_d;
    logic             done_q, done_d;
    logic             bypass_q, bypass_d;
    logic [CW-1:0]    coef_cnt_q, coef_cnt_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    logic [COEF_W-1:0] cand_s;
    logic              accept_s, full_s, stall_s, extract_s, s_ready_s, s_fire_s;
    logic [BUF_W-1:0]  buf_sh_s;
    logic [BCW-1:0]    cnt_sh_s;
    logic [OW-1:0]     slot_ins_s;

    // Handshake qualifiers; a rejected candidate never completes a pack, so it never stalls
    always_comb begin
        cand_s    = buf_q[COEF_W-1:0];
        accept_s  = bypass_q || (32'(cand_s) < 32'(Q));
        full_s    = accept_s && (slot_cnt_q == SW'(PACK - 1));
        stall_s   = m_valid_q && !m_ready && full_s;
        s_ready_s = (state_q == ST_RUN) && (buf_cnt_q <= BCW'(BUF_W - DIN_W))
                    && (coef_cnt_q < CW'(NCOEF));
        s_fire_s  = s_valid && s_ready_s;
        extract_s = (state_q == ST_RUN) && (buf_cnt_q >= BCW'(COEF_W))
                    && (coef_cnt_q < CW'(NCOEF)) && !stall_s;
        slot_ins_s = slot_q;
        for (int i = 0; i < PACK; i++) begin
            if (slot_cnt_q == SW'(i)) begin
                slot_ins_s[i*COEF_W +: COEF_W] = cand_s;
            end else begin
                slot_ins_s[i*COEF_W +: COEF_W] = slot_q[i*COEF_W +: COEF_W];
            end
        end
    end

    // Next-state logic for the buffer, pack slots, output register and counters
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_cnt_d  = buf_cnt_q;
        slot_d     = slot_q;
        slot_cnt_d = slot_cnt_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        done_d     = done_q;
        bypass_d   = bypass_q;
        coef_cnt_d = coef_cnt_q;
        drop_cnt_d = drop_cnt_q;
        buf_sh_s   = buf_q;
        cnt_sh_s   = buf_cnt_q;
        if (start) begin
            state_d    = ST_RUN;
            buf_d      = '0;
            buf_cnt_d  = '0;
            slot_d     = '0;
            slot_cnt_d = '0;
            m_valid_d  = 1'b0;
            m_last_d   = 1'b0;
            done_d     = 1'b0;
            bypass_d   = bypass;
            coef_cnt_d = '0;
            drop_cnt_d = 16'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (m_valid_q && m_ready) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                    end else begin
                        m_valid_d = m_valid_q;
                    end
                    if (extract_s) begin
                        buf_sh_s = buf_q >> COEF_W;
                        cnt_sh_s = buf_cnt_q - BCW'(COEF_W);
                        if (accept_s) begin
                            coef_cnt_d = coef_cnt_q + CW'(1);
                            if (full_s) begin
                                m_data_d   = slot_ins_s;
                                m_valid_d  = 1'b1;
                                m_last_d   = (coef_cnt_q == CW'(NCOEF - 1));
                                slot_d     = '0;
                                slot_cnt_d = '0;
                            end else begin
                                slot_d     = slot_ins_s;
                                slot_cnt_d = slot_cnt_q + SW'(1);
                            end
                        end else begin
                            drop_cnt_d = sat_inc16(drop_cnt_q);
                        end
                    end else begin
                        buf_sh_s = buf_q;
                    end
                    // New word lands directly above whatever survives this cycle's extraction
                    if (s_fire_s) begin
                        buf_d     = buf_sh_s | (BUF_W'(s_data) << cnt_sh_s);
                        buf_cnt_d = cnt_sh_s + BCW'(DIN_W);
                    end else begin
                        buf_d     = buf_sh_s;
                        buf_cnt_d = cnt_sh_s;
                    end
                    if (coef_cnt_d == CW'(NCOEF)) begin
                        state_d   = ST_DRAIN;
                        buf_d     = '0;
                        buf_cnt_d = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (m_valid_q && m_ready) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        done_d    = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    m_valid_d = 1'b0;
                    done_d    = 1'b1;
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            buf_cnt_q  <= '0;
            slot_q     <= '0;
            slot_cnt_q <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            done_q     <= 1'b0;
            bypass_q   <= 1'b0;
            coef_cnt_q <= '0;
            drop_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_cnt_q  <= buf_cnt_d;
            slot_q     <= slot_d;
            slot_cnt_q <= slot_cnt_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            done_q     <= done_d;
            bypass_q   <= bypass_d;
            coef_cnt_q <= coef_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign s_ready  = s_ready_s;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_last   = m_last_q;
    assign done     = done_q;
    assign coef_cnt = coef_cnt_q;
    assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_rej_sample_packer.sv
// Scoreboard bench for rej_sample_packer: expected words are queued at stimulus time,
// a monitor pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_rej_sample_packer;
    logic        clk = 1'b0;
    logic        rst, start, bypass, s_valid, m_ready;
    logic [31:0] s_data;
    logic        s_ready, m_valid, m_last, done;
    logic [23:0] m_data;
    logic [8:0]  coef_cnt;
    logic [15:0] drop_cnt;

    typedef struct packed {
        logic [23:0] d;
        logic        l;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] words[0:199];
    int          n_pass = 0;
    int          n_chk  = 0;
    int          out_cnt = 0;
    logic        bp_drop = 1'b0;
    logic        done_chk = 1'b0;
    logic        hold_prev = 1'b0;
    logic [23:0] hold_data;
    logic        hold_last;
    int          model_drops;

    rej_sample_packer dut (
        .clk(clk), .rst(rst), .start(start), .bypass(bypass),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .done(done), .coef_cnt(coef_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: event did not occur within its bound", name);
    endtask

    task automatic do_start(input logic b);
        @(posedge clk); #1;
        start = 1'b1; bypass = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer words[0..n-1] in order; m_ready is forced low inside [bp_lo, bp_hi)
    task automatic feed(input int n, input int bp_lo, input int bp_hi, input logic mr);
        int i = 0;
        int cyc = 0;
        while (i < n && cyc < 3000 && coef_cnt != 9'd256) begin
            s_valid = 1'b1;
            s_data  = words[i];
            m_ready = (cyc >= bp_lo && cyc < bp_hi) ? 1'b0 : mr;
            @(negedge clk);
            if (cyc >= bp_lo && cyc < bp_hi && !s_ready) bp_drop = 1'b1;
            if (s_ready) i++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        m_ready = mr;
        if (cyc >= 3000) fail_now("feed_timeout");
    endtask

    task automatic wait_done();
        int c = 0;
        while (!done && c < 1000) begin
            @(negedge clk);
            c++;
        end
        if (!done) fail_now("done_timeout");
    endtask

    // Reference: bit accumulator over the word list, first 256 accepted candidates
    task automatic build_model(input int n, input logic byp, output int drops);
        logic [127:0] acc;
        logic [11:0]  c;
        logic [23:0]  pk;
        exp_t         e;
        int           nb, nc;
        acc = '0; nb = 0; nc = 0; drops = 0; pk = '0;
        for (int i = 0; i < n && nc < 256; i++) begin
            acc = acc | ({96'd0, words[i]} << nb);
            nb += 32;
            while (nb >= 12 && nc < 256) begin
                c   = acc[11:0];
                acc = acc >> 12;
                nb -= 12;
                if (byp || c < 12'd3329) begin
                    pk[(nc % 2) * 12 +: 12] = c;
                    nc++;
                    if (nc % 2 == 0) begin
                        e.d = pk;
                        e.l = (nc == 256);
                        exp_q.push_back(e);
                    end
                end else begin
                    drops++;
                end
            end
        end
    endtask

    // Monitor: compare every handshaken word, hold stability and done timing
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_chk) begin
                check("done_after_last", {63'd0, done}, 64'd1);
                done_chk = 1'b0;
            end
            if (hold_prev && m_valid) begin
                check("hold_data", {40'd0, m_data}, {40'd0, hold_data});
                check("hold_last", {63'd0, m_last}, {63'd0, hold_last});
            end
            if (m_valid && m_ready && rst) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_word");
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", {40'd0, m_data}, {40'd0, e.d});
                    check("out_last", {63'd0, m_last}, {63'd0, e.l});
                    if (m_last) begin
                        check("done_at_last", {63'd0, done}, 64'd0);
                        done_chk = 1'b1;
                    end
                end
            end
            hold_prev = m_valid && !m_ready;
            hold_data = m_data;
            hold_last = m_last;
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; bypass = 1'b0; s_valid = 1'b0; s_data = 32'd0; m_ready = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("rst_s_ready", {63'd0, s_ready}, 64'd0);
        check("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("rst_m_data", {40'd0, m_data}, 64'd0);
        check("rst_m_last", {63'd0, m_last}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_coef_cnt", {55'd0, coef_cnt}, 64'd0);
        check("rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("idle_s_ready", {63'd0, s_ready}, 64'd0);

        // Reject boundary: 0xD00 accepted, 0xD01 rejected
        do_start(1'b0);
        words[0] = 32'h00D01D00;
        feed(1, -1, -1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("bound_drop_cnt", {48'd0, drop_cnt}, 64'd1);
        check("bound_coef_cnt", {55'd0, coef_cnt}, 64'd1);
        check("bound_m_valid", {63'd0, m_valid}, 64'd0);

        // Bypass: both candidates kept, word valid after the second extraction
        do_start(1'b1);
        exp_q.push_back('{d: 24'hD01D00, l: 1'b0});
        feed(1, -1, -1, 1'b1);
        @(posedge clk); #1;
        check("byp_valid_early", {63'd0, m_valid}, 64'd0);
        @(posedge clk); #1;
        check("byp_valid", {63'd0, m_valid}, 64'd1);
        check("byp_coef_cnt", {55'd0, coef_cnt}, 64'd2);
        check("byp_drop_cnt", {48'd0, drop_cnt}, 64'd0);
        repeat (3) @(posedge clk);
        #1 check("byp_drained", exp_q.size(), 64'd0);

        // Full run, free-flowing output
        for (int i = 0; i < 200; i++) words[i] = $urandom;
        do_start(1'b0);
        build_model(200, 1'b0, model_drops);
        out_cnt = 0;
        feed(200, -1, -1, 1'b1);
        wait_done();
        repeat (2) @(posedge clk);
        #1;
        check("full_out_cnt", out_cnt, 64'd128);
        check("full_queue_empty", exp_q.size(), 64'd0);
        check("full_coef_cnt", {55'd0, coef_cnt}, 64'd256);
        check("full_drop_cnt", {48'd0, drop_cnt}, model_drops);
        check("full_done", {63'd0, done}, 64'd1);
        check("full_s_ready", {63'd0, s_ready}, 64'd0);

        // Full run with a 20-cycle output stall
        for (int i = 0; i < 200; i++) words[i] = $urandom;
        do_start(1'b0);
        build_model(200, 1'b0, model_drops);
        out_cnt = 0;
        bp_drop = 1'b0;
        feed(200, 30, 50, 1'b1);
        wait_done();
        repeat (2) @(posedge clk);
        #1;
        check("bp_out_cnt", out_cnt, 64'd128);
        check("bp_queue_empty", exp_q.size(), 64'd0);
        check("bp_s_ready_dropped", {63'd0, bp_drop}, 64'd1);
        check("bp_drop_cnt", {48'd0, drop_cnt}, model_drops);

        // Restart while a word is pending: that word is lost, old residue discarded
        do_start(1'b1);
        words[0] = 32'h5AD01D00;
        feed(1, -1, -1, 1'b0);
        repeat (3) @(posedge clk);
        #1 check("restart_pending", {63'd0, m_valid}, 64'd1);
        do_start(1'b1);
        check("restart_m_valid", {63'd0, m_valid}, 64'd0);
        check("restart_coef_cnt", {55'd0, coef_cnt}, 64'd0);
        check("restart_drop_cnt", {48'd0, drop_cnt}, 64'd0);
        words[0] = 32'h00ABC123;
        exp_q.push_back('{d: 24'hABC123, l: 1'b0});
        feed(1, -1, -1, 1'b1);
        repeat (4) @(posedge clk);
        #1 check("restart_new_word", exp_q.size(), 64'd0);

        // Asynchronous reset between edges mid-run
        do_start(1'b1);
        words[0] = 32'h12345678;
        words[1] = 32'h9ABCDEF0;
        feed(2, -1, -1, 1'b0);
        repeat (3) @(posedge clk);
        #1 check("pre_reset_valid", {63'd0, m_valid}, 64'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("arst_m_valid", {63'd0, m_valid}, 64'd0);
        check("arst_m_data", {40'd0, m_data}, 64'd0);
        check("arst_m_last", {63'd0, m_last}, 64'd0);
        check("arst_done", {63'd0, done}, 64'd0);
        check("arst_coef_cnt", {55'd0, coef_cnt}, 64'd0);
        check("arst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
        check("arst_s_ready", {63'd0, s_ready}, 64'd0);
        @(negedge clk) rst = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'hFFFFFFFF;
        repeat (3) @(posedge clk);
        #1 check("post_rst_s_ready", {63'd0, s_ready}, 64'd0);
        s_valid = 1'b0;
        do_start(1'b0);
        check("post_start_s_ready", {63'd0, s_ready}, 64'd1);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
